// File: rtl/reg_scoreboard_pkg.sv
// Shared types and helpers for the register busy-bit scoreboard.
// Covers the table geometry, the flush FSM states and the mask check.
package scoreboard_pkg;

    localparam int NREGS = 32;
    localparam int IDXW  = 5;
    localparam int CNTW  = 6;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } sb_state_t;

    // True when the mask has at most one bit set.
    function automatic logic is_onehot0(input logic [NREGS-1:0] mask);
        return (mask & (mask - NREGS'(1))) == '0;
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_hazard_check.sv
// Combinational RAW/WAW hazard detect against the bypassed busy bits.
module sb_hazard_check
    import scoreboard_pkg::*;
(
    input  logic [NREGS-1:0] busy_eff,
    input  logic [IDXW-1:0]  rs1,
    input  logic [IDXW-1:0]  rs2,
    input  logic [IDXW-1:0]  rd,
    input  logic             wr,
    output logic             haz
);

    assign haz = busy_eff[rs1] | busy_eff[rs2] | (wr & busy_eff[rd]);

endmodule

// File: rtl/reg_scoreboard.sv
// 32-entry busy-bit scoreboard: issue handshake, writeback clear with
// same-cycle bypass, and a RUN/DRAIN/CLEAR flush state machine.
module reg_scoreboard
    import scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [IDXW-1:0]   issue_rs1,
    input  logic [IDXW-1:0]   issue_rs2,
    input  logic [IDXW-1:0]   issue_rd,
    input  logic              issue_wr,
    output logic              issue_ready,
    input  logic [NREGS-1:0]  wb_clr_mask,
    input  logic              flush_req,
    output logic              flush_done,
    output logic [NREGS-1:0]  busy_vec,
    output logic [CNTW-1:0]   outstanding,
    output logic              wb_err
);

    sb_state_t        state;
    logic [NREGS-1:0] mask_m;
    logic             wb_ok;
    logic [NREGS-1:0] clr_vec;
    logic [NREGS-1:0] busy_eff;
    logic             haz;
    logic             accept;
    logic             do_set;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] busy_next;
    logic [CNTW-1:0]  cnt_next;

    // Register 0 is hard-wired idle, so its mask bit is dropped before any check.
    assign mask_m  = wb_clr_mask & ~NREGS'(1);
    assign wb_ok   = (mask_m != '0) && is_onehot0(mask_m) && ((mask_m & ~busy_vec) == '0);
    assign clr_vec = wb_ok ? mask_m : '0;

    // A rejected mask clears nothing, so it must not release a hazard either.
    assign busy_eff = busy_vec & ~clr_vec;

    sb_hazard_check u_hazard (
        .busy_eff (busy_eff),
        .rs1      (issue_rs1),
        .rs2      (issue_rs2),
        .rd       (issue_rd),
        .wr       (issue_wr),
        .haz      (haz)
    );

    assign issue_ready = rst_n && (state == RUN) && !flush_req && !haz;
    assign accept      = issue_valid && issue_ready;
    assign do_set      = accept && issue_wr && (issue_rd != '0);
    assign set_vec     = do_set ? (NREGS'(1) << issue_rd) : '0;

    // Set is applied after clear so a same-register clear+set keeps the bit.
    assign busy_next = (busy_vec & ~clr_vec) | set_vec;
    assign cnt_next  = outstanding + CNTW'(do_set) - CNTW'(wb_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            busy_vec    <= '0;
            outstanding <= '0;
            flush_done  <= 1'b0;
            wb_err      <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            wb_err     <= (mask_m != '0) && !wb_ok;
            case (state)
                RUN: begin
                    busy_vec    <= busy_next;
                    outstanding <= cnt_next;
                    if (flush_req) state <= DRAIN;
                end
                DRAIN: begin
                    busy_vec    <= busy_next;
                    outstanding <= cnt_next;
                    if (cnt_next == '0) state <= CLEAR;
                end
                CLEAR: begin
                    busy_vec    <= '0;
                    outstanding <= '0;
                    flush_done  <= 1'b1;
                    state       <= flush_req ? DRAIN : RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    a_count_matches: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding == CNTW'($countones(busy_vec)));

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus a
// randomized run scored against a behavioural busy-table model.
module tb_reg_scoreboard;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          issue_valid;
    logic [4:0]    issue_rs1, issue_rs2, issue_rd;
    logic          issue_wr;
    logic          issue_ready;
    logic [N-1:0]  wb_clr_mask;
    logic          flush_req;
    logic          flush_done;
    logic [N-1:0]  busy_vec;
    logic [5:0]    outstanding;
    logic          wb_err;

    int tests = 0;
    int fails = 0;

    // Behavioural model: a table of busy flags plus flush mode (0 run, 1 drain, 2 clear).
    bit m_busy [N];
    int m_mode;
    bit m_fd, m_err;

    reg_scoreboard dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rs1   (issue_rs1),
        .issue_rs2   (issue_rs2),
        .issue_rd    (issue_rd),
        .issue_wr    (issue_wr),
        .issue_ready (issue_ready),
        .wb_clr_mask (wb_clr_mask),
        .flush_req   (flush_req),
        .flush_done  (flush_done),
        .busy_vec    (busy_vec),
        .outstanding (outstanding),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    // Index of the register a legal writeback clears, or -1 if the mask clears nothing.
    function automatic int wb_target();
        int n = 0;
        int idx = -1;
        bit ok = 1;
        for (int i = 1; i < N; i++) begin
            if (wb_clr_mask[i]) begin
                n++;
                idx = i;
                if (!m_busy[i]) ok = 0;
            end
        end
        return (ok && n == 1) ? idx : -1;
    endfunction

    function automatic int mask_bits();
        int n = 0;
        for (int i = 1; i < N; i++) if (wb_clr_mask[i]) n++;
        return n;
    endfunction

    function automatic bit still_busy(input int r);
        return m_busy[r] && (wb_target() != r);
    endfunction

    function automatic bit model_ready();
        bit hz;
        hz = still_busy(issue_rs1) || still_busy(issue_rs2) || (issue_wr && still_busy(issue_rd));
        return rst_n && (m_mode == 0) && !flush_req && !hz;
    endfunction

    function automatic logic [N-1:0] model_vec();
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (m_busy[i]) c++;
        return c;
    endfunction

    task automatic model_edge();
        bit rdy;
        int t;
        rdy = model_ready();
        if (!rst_n) begin
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            m_mode = 0; m_fd = 0; m_err = 0;
            return;
        end
        t = wb_target();
        m_err = (mask_bits() > 0) && (t < 0);
        m_fd = 0;
        if (m_mode == 2) begin
            for (int i = 0; i < N; i++) m_busy[i] = 0;
            m_fd = 1;
            m_mode = flush_req ? 1 : 0;
            return;
        end
        if (t > 0) m_busy[t] = 0;
        if (rdy && issue_valid && issue_wr && issue_rd != 0) m_busy[issue_rd] = 1;
        if (m_mode == 0 && flush_req) m_mode = 1;
        else if (m_mode == 1 && model_count() == 0) m_mode = 2;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0; issue_wr = 0;
        wb_clr_mask = '0; flush_req = 0;
    endtask

    task automatic drive_issue(input int rs1, input int rs2, input int rd, input bit wr);
        issue_valid = 1; issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2); issue_rd = 5'(rd); issue_wr = wr;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        drive_issue(1, 2, 3, 1);
        #1;
        tests++;
        if (issue_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b want=0", issue_ready); end
        tick(); tick();
        tests++;
        if (busy_vec !== '0 || outstanding !== 6'd0 || flush_done !== 1'b0 || wb_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got busy=%h out=%0d fd=%b err=%b want all zero", busy_vec, outstanding, flush_done, wb_err);
        end
        idle_inputs();
        rst_n = 1;
        #1;
    endtask

    task automatic test_issue();
        drive_issue(1, 2, 3, 1);
        #1;
        tests++;
        if (issue_ready !== 1'b1) begin fails++; $display("FAIL issue_ready got=%b want=1", issue_ready); end
        tick();
        idle_inputs();
        tests++;
        if (busy_vec !== 32'h8 || outstanding !== 6'd1) begin
            fails++; $display("FAIL issue_busy got busy=%h out=%0d want busy=8 out=1", busy_vec, outstanding);
        end
    endtask

    task automatic test_bypass();
        drive_issue(3, 0, 0, 0);
        #1;
        tests++;
        if (issue_ready !== 1'b0) begin fails++; $display("FAIL raw_stall got=%b want=0", issue_ready); end
        wb_clr_mask = 32'h8;
        #1;
        tests++;
        if (issue_ready !== 1'b1) begin fails++; $display("FAIL wb_bypass got=%b want=1", issue_ready); end
        tick();
        idle_inputs();
        tests++;
        if (busy_vec !== '0 || outstanding !== 6'd0) begin
            fails++; $display("FAIL wb_clear got busy=%h out=%0d want 0/0", busy_vec, outstanding);
        end
    endtask

    task automatic test_same_cycle();
        drive_issue(0, 0, 5, 1);
        tick();
        drive_issue(0, 0, 5, 1);
        wb_clr_mask = 32'h20;
        #1;
        tests++;
        if (issue_ready !== 1'b1) begin fails++; $display("FAIL waw_bypass got=%b want=1", issue_ready); end
        tick();
        idle_inputs();
        tests++;
        if (busy_vec !== 32'h20 || outstanding !== 6'd1) begin
            fails++; $display("FAIL set_wins got busy=%h out=%0d want busy=20 out=1", busy_vec, outstanding);
        end
        wb_clr_mask = 32'h20;
        tick();
        idle_inputs();
    endtask

    task automatic test_wb_err();
        drive_issue(0, 0, 4, 1); tick();
        drive_issue(0, 0, 5, 1); tick();
        idle_inputs();
        wb_clr_mask = 32'h30;
        tick();
        idle_inputs();
        tests++;
        if (wb_err !== 1'b1 || busy_vec !== 32'h30 || outstanding !== 6'd2) begin
            fails++; $display("FAIL err_twohot got err=%b busy=%h out=%0d want 1/30/2", wb_err, busy_vec, outstanding);
        end
        tick();
        tests++;
        if (wb_err !== 1'b0) begin fails++; $display("FAIL err_pulse got=%b want=0", wb_err); end
        wb_clr_mask = 32'h40;
        tick();
        idle_inputs();
        tests++;
        if (wb_err !== 1'b1 || busy_vec !== 32'h30) begin
            fails++; $display("FAIL err_idle got err=%b busy=%h want 1/30", wb_err, busy_vec);
        end
        wb_clr_mask = 32'h1;
        tick();
        idle_inputs();
        tests++;
        if (wb_err !== 1'b0 || busy_vec !== 32'h30) begin
            fails++; $display("FAIL mask_bit0 got err=%b busy=%h want 0/30", wb_err, busy_vec);
        end
        wb_clr_mask = 32'h10; tick();
        wb_clr_mask = 32'h20; tick();
        idle_inputs();
    endtask

    task automatic test_flush();
        drive_issue(0, 0, 3, 1); tick();
        drive_issue(0, 0, 7, 1); tick();
        idle_inputs();
        flush_req = 1;
        drive_issue(1, 2, 9, 1);
        #1;
        tests++;
        if (issue_ready !== 1'b0) begin fails++; $display("FAIL flush_block got=%b want=0", issue_ready); end
        tick();
        idle_inputs();
        wb_clr_mask = 32'h8;
        tick();
        idle_inputs();
        drive_issue(1, 2, 9, 1);
        #1;
        tests++;
        if (issue_ready !== 1'b0 || busy_vec !== 32'h80 || outstanding !== 6'd1) begin
            fails++; $display("FAIL drain got rdy=%b busy=%h out=%0d want 0/80/1", issue_ready, busy_vec, outstanding);
        end
        idle_inputs();
        wb_clr_mask = 32'h80;
        tick();
        idle_inputs();
        tests++;
        if (issue_ready !== 1'b0 || flush_done !== 1'b0 || busy_vec !== '0) begin
            fails++; $display("FAIL clear_state got rdy=%b fd=%b busy=%h want 0/0/0", issue_ready, flush_done, busy_vec);
        end
        tick();
        tests++;
        if (flush_done !== 1'b1 || busy_vec !== '0 || outstanding !== 6'd0 || issue_ready !== 1'b1) begin
            fails++; $display("FAIL flush_done got fd=%b busy=%h out=%0d rdy=%b want 1/0/0/1", flush_done, busy_vec, outstanding, issue_ready);
        end
        tick();
        tests++;
        if (flush_done !== 1'b0) begin fails++; $display("FAIL fd_pulse got=%b want=0", flush_done); end
    endtask

    task automatic test_rd0();
        drive_issue(0, 0, 0, 1);
        tick();
        idle_inputs();
        tests++;
        if (busy_vec !== '0 || outstanding !== 6'd0) begin
            fails++; $display("FAIL rd0 got busy=%h out=%0d want 0/0", busy_vec, outstanding);
        end
    endtask

    task automatic test_reset_midflush();
        drive_issue(0, 0, 9, 1); tick();
        idle_inputs();
        flush_req = 1;
        tick();
        idle_inputs();
        rst_n = 0;
        tick();
        tests++;
        if (busy_vec !== '0 || outstanding !== 6'd0 || flush_done !== 1'b0 || wb_err !== 1'b0) begin
            fails++; $display("FAIL rst_drain got busy=%h out=%0d fd=%b err=%b want zeros", busy_vec, outstanding, flush_done, wb_err);
        end
        rst_n = 1;
        drive_issue(1, 2, 3, 1);
        #1;
        tests++;
        if (issue_ready !== 1'b1) begin fails++; $display("FAIL rst_run got rdy=%b want=1", issue_ready); end
        idle_inputs();
        tick();
        tests++;
        if (flush_done !== 1'b0) begin fails++; $display("FAIL rst_no_fd got=%b want=0", flush_done); end
    endtask

    task automatic test_random();
        int busy_list [$];
        for (int cyc = 0; cyc < 2000; cyc++) begin
            rst_n       = ($urandom_range(0, 299) != 0);
            issue_valid = $urandom_range(0, 3) != 0;
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_rd    = 5'($urandom_range(0, 7));
            issue_wr    = $urandom_range(0, 3) != 0;
            flush_req   = ($urandom_range(0, 39) == 0);
            busy_list.delete();
            for (int i = 1; i < N; i++) if (m_busy[i]) busy_list.push_back(i);
            case ($urandom_range(0, 5))
                0, 1:    wb_clr_mask = '0;
                2, 3:    wb_clr_mask = (busy_list.size() > 0) ?
                             (32'h1 << busy_list[$urandom_range(0, busy_list.size() - 1)]) : '0;
                4:       wb_clr_mask = 32'h1 << $urandom_range(0, 31);
                default: wb_clr_mask = $urandom;
            endcase
            #1;
            tests++;
            if (issue_ready !== model_ready()) begin
                fails++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, issue_ready, model_ready());
            end
            tick();
            tests++;
            if (busy_vec !== model_vec() || outstanding !== 6'(model_count())) begin
                fails++; $display("FAIL rnd_table cyc=%0d got busy=%h out=%0d want busy=%h out=%0d",
                                  cyc, busy_vec, outstanding, model_vec(), model_count());
            end
            tests++;
            if (wb_err !== m_err || flush_done !== m_fd) begin
                fails++; $display("FAIL rnd_pulse cyc=%0d got err=%b fd=%b want err=%b fd=%b",
                                  cyc, wb_err, flush_done, m_err, m_fd);
            end
        end
        idle_inputs();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        m_mode = 0; m_fd = 0; m_err = 0;
        for (int i = 0; i < N; i++) m_busy[i] = 0;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_issue();
        test_bypass();
        test_same_cycle();
        test_wb_err();
        test_flush();
        test_rd0();
        test_reset_midflush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
